// File: rtl/ifm_loader_if.sv
// ifm_loader_if: DMA stream, control and BRAM write-port signals of the IFM loader
interface ifm_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 20
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_words;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              wr_rd_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              done;
  logic              err;
  modport master (
    output start, abort, base_addr, num_words, s_valid, s_data,
    input  s_ready, wr_rd_en, wr_addr, data_in, busy, done, err
  );
  modport slave (
    input  start, abort, base_addr, num_words, s_valid, s_data,
    output s_ready, wr_rd_en, wr_addr, data_in, busy, done, err
  );
endinterface

// File: rtl/ifm_loader.sv
// ifm_loader: turns a valid/ready word stream into IFM BRAM write strobes with range checking
module ifm_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 20,
  parameter int DEPTH  = 26912
) (
  input logic         clk,
  input logic         rst_n,
  ifm_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  rem;
  logic [ADDR_W:0]   end_addr;
  logic              range_bad;
  logic              zero_len;
  logic              hs;
  assign end_addr  = {1'b0, bus.base_addr} + (ADDR_W+1)'(bus.num_words);
  assign zero_len  = bus.num_words == '0;
  assign range_bad = !zero_len && end_addr > LIMIT;
  assign bus.s_ready = state == LOAD && rem != '0;
  assign hs = bus.s_valid && bus.s_ready;
  // control FSM with registered BRAM strobes and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      rem          <= '0;
      bus.wr_rd_en <= 1'b0;
      bus.wr_addr  <= '0;
      bus.data_in  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
    end else if (bus.abort) begin
      state        <= IDLE;
      bus.wr_rd_en <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.wr_rd_en <= 1'b0;
      bus.done     <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          addr    <= bus.base_addr;
          rem     <= bus.num_words;
          bus.err <= range_bad;
          if (zero_len || range_bad) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state    <= LOAD;
            bus.busy <= 1'b1;
          end
        end
        LOAD: if (hs) begin
          bus.wr_rd_en <= 1'b1;
          bus.wr_addr  <= addr;
          bus.data_in  <= DATA_W'(bus.s_data);
          addr         <= addr + ADDR_W'(1);
          rem          <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) state <= FLUSH;
        end
        FLUSH: begin
          state    <= DONE;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifm_loader.sv
// tb_ifm_loader: table-driven cycle vectors plus a mid-load reset sequence for ifm_loader
module tb_ifm_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ifm_loader_if bus ();
  ifm_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic        st, ab, vl;
    logic [31:0] base;
    logic [19:0] num;
    logic [31:0] dat;
    logic [68:0] exp;
  } vec_t;
  vec_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  // one cycle: inputs for the cycle, then {s_ready, wr_rd_en, wr_addr, data_in, busy, done, err} seen in it
  task automatic r(input logic st, ab, vl, input logic [31:0] base, input logic [19:0] num,
                   input logic [31:0] dat, input logic rdy, wr, input logic [31:0] addr, din,
                   input logic bsy, dn, er);
    vec_t v;
    v.st = st; v.ab = ab; v.vl = vl; v.base = base; v.num = num; v.dat = dat;
    v.exp = {rdy, wr, addr, din, bsy, dn, er};
    q.push_back(v);
  endtask
  function automatic logic [68:0] obs();
    return {bus.s_ready, bus.wr_rd_en, bus.wr_addr, bus.data_in, bus.busy, bus.done, bus.err};
  endfunction
  task automatic check(input string name, input logic [68:0] exp);
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, obs(), exp);
    end
  endtask
  task automatic idle_inputs();
    bus.start = 0; bus.abort = 0; bus.s_valid = 0; bus.base_addr = 0; bus.num_words = 0; bus.s_data = 0;
  endtask
  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #1 check("reset_state", '0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
  endtask
  task automatic run(input string name);
    foreach (q[i]) begin
      bus.start = q[i].st; bus.abort = q[i].ab; bus.s_valid = q[i].vl;
      bus.base_addr = q[i].base; bus.num_words = q[i].num; bus.s_data = q[i].dat;
      #1 check($sformatf("%s[%0d]", name, i), q[i].exp);
      @(posedge clk);
      #1;
    end
    q.delete();
    idle_inputs();
  endtask
  initial begin
    idle_inputs();
    do_reset();
    r(1,0,0,0,4,0,         0,0,0,0,0,0,0);
    r(0,0,1,0,0,'hA0,      1,0,0,0,1,0,0);
    r(0,0,1,0,0,'hA1,      1,1,0,'hA0,1,0,0);
    r(0,0,1,0,0,'hA2,      1,1,1,'hA1,1,0,0);
    r(0,0,1,0,0,'hA3,      1,1,2,'hA2,1,0,0);
    r(0,0,0,0,0,0,         0,1,3,'hA3,1,0,0);
    r(0,0,0,0,0,0,         0,0,3,'hA3,0,1,0);
    r(0,0,0,0,0,0,         0,0,3,'hA3,0,0,0);
    run("basic");
    do_reset();
    r(1,0,0,10,3,0,        0,0,0,0,0,0,0);
    r(0,0,1,0,0,'hB0,      1,0,0,0,1,0,0);
    r(0,0,0,0,0,'hB1,      1,1,10,'hB0,1,0,0);
    r(0,0,0,0,0,'hB2,      1,0,10,'hB0,1,0,0);
    r(0,0,1,0,0,'hB3,      1,0,10,'hB0,1,0,0);
    r(0,0,0,0,0,'hB4,      1,1,11,'hB3,1,0,0);
    r(0,0,1,0,0,'hB5,      1,0,11,'hB3,1,0,0);
    r(0,0,1,0,0,'hFF,      0,1,12,'hB5,1,0,0);
    r(0,0,0,0,0,0,         0,0,12,'hB5,0,1,0);
    r(0,0,0,0,0,0,         0,0,12,'hB5,0,0,0);
    run("throttle");
    do_reset();
    r(1,0,0,26908,4,0,     0,0,0,0,0,0,0);
    r(0,0,1,0,0,'hC0,      1,0,0,0,1,0,0);
    r(0,0,1,0,0,'hC1,      1,1,26908,'hC0,1,0,0);
    r(0,0,1,0,0,'hC2,      1,1,26909,'hC1,1,0,0);
    r(0,0,1,0,0,'hC3,      1,1,26910,'hC2,1,0,0);
    r(0,0,0,0,0,0,         0,1,26911,'hC3,1,0,0);
    r(0,0,0,0,0,0,         0,0,26911,'hC3,0,1,0);
    r(0,0,0,0,0,0,         0,0,26911,'hC3,0,0,0);
    run("range_ok");
    do_reset();
    r(1,0,1,26909,4,'hD0,  0,0,0,0,0,0,0);
    r(0,0,1,0,0,'hD0,      0,0,0,0,0,1,1);
    r(0,0,1,0,0,'hD0,      0,0,0,0,0,0,1);
    r(1,0,1,0,0,'hD1,      0,0,0,0,0,0,1);
    r(0,0,1,0,0,'hD1,      0,0,0,0,0,1,0);
    r(0,0,1,0,0,'hD1,      0,0,0,0,0,0,0);
    run("range_bad_zero");
    do_reset();
    r(1,0,0,100,8,0,       0,0,0,0,0,0,0);
    r(0,0,1,0,0,'hD0,      1,0,0,0,1,0,0);
    r(0,0,1,0,0,'hD1,      1,1,100,'hD0,1,0,0);
    r(0,1,1,0,0,'hD2,      1,1,101,'hD1,1,0,0);
    r(0,0,1,0,0,'hD3,      0,0,101,'hD1,0,0,0);
    r(0,0,1,0,0,'hD4,      0,0,101,'hD1,0,0,0);
    r(1,0,0,200,2,0,       0,0,101,'hD1,0,0,0);
    r(0,0,1,0,0,'hE0,      1,0,101,'hD1,1,0,0);
    r(0,0,1,0,0,'hE1,      1,1,200,'hE0,1,0,0);
    r(0,0,0,0,0,0,         0,1,201,'hE1,1,0,0);
    r(0,0,0,0,0,0,         0,0,201,'hE1,0,1,0);
    r(0,0,0,0,0,0,         0,0,201,'hE1,0,0,0);
    run("abort");
    do_reset();
    r(1,0,0,50,8,0,        0,0,0,0,0,0,0);
    r(0,0,1,0,0,'hF0,      1,0,0,0,1,0,0);
    r(1,0,1,0,1,'hF1,      1,1,50,'hF0,1,0,0);
    r(0,0,1,0,0,'hF2,      1,1,51,'hF1,1,0,0);
    r(0,0,1,0,0,'hF3,      1,1,52,'hF2,1,0,0);
    r(0,0,0,0,0,0,         1,1,53,'hF3,1,0,0);
    r(0,0,0,0,0,0,         1,0,53,'hF3,1,0,0);
    run("ignored_start");
    bus.s_valid = 1;
    bus.s_data = 'h99;
    #2 rst_n = 0;
    #1 check("reset_mid_load", '0);
    @(posedge clk);
    #1 check("reset_held", '0);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check($sformatf("post_reset[%0d]", i), '0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
